// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV64 main controller.
//   state_t   : controller states
//   OPC_*     : 5-bit major opcodes (inst[6:2]) understood by the controller
//   ALU_*     : alu_op encodings driven towards the ALU control
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BRCMP = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle main controller for the RV64 integer datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB for LOAD, STORE, BRANCH, OP-IMM and OP.
//
// Configuration macro: MC_CTRL_TRAP_EN
//   defined   : unsupported opcode enters TRAP and sets the sticky trap flag
//   undefined : unsupported opcode retires as a NOP, trap tied to 0
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   inst                  current IR contents (opcode decoded from inst[6:2])
//   imem_req/imem_ready   instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready  data access handshake (we: 1 = store)
//   br_taken              branch compare result, sampled in EXEC
//   ir_we, pc_we, pc_sel  IR / PC update controls (pc_sel 1 = branch target)
//   rf_we, wb_sel         register write enable, write-back source (1 = load)
//   alu_src_imm, alu_op   ALU operand B select and operation class
//   instret               retired-instruction counter (wraps)
//   trap                  illegal-instruction flag
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 br_taken,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 rf_we,
  output logic                 alu_src_imm,
  output logic [1:0]           alu_op,
  output logic                 wb_sel,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  state_t     state, state_next;
  logic       retire;
  logic [4:0] opc;
  logic       unused_inst;

  assign opc         = inst[6:2];
  assign unused_inst = ^{inst[31:7], inst[1:0]};

`ifdef MC_CTRL_TRAP_EN
  logic trap_set;
  logic trap_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    rf_we       = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    wb_sel      = 1'b0;
`ifdef MC_CTRL_TRAP_EN
    trap_set    = 1'b0;
`endif
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        case (opc)
          OPC_OPIMM: begin
            alu_src_imm = 1'b1;
            alu_op      = ALU_FUNCT;
            state_next  = WB;
          end
          OPC_OP: begin
            alu_op     = ALU_FUNCT;
            state_next = WB;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_imm = 1'b1;
            state_next  = MEM;
          end
          OPC_BRANCH: begin
            alu_op     = ALU_BRCMP;
            pc_we      = br_taken;
            pc_sel     = br_taken;
            retire     = 1'b1;
            state_next = FETCH;
          end
          default: begin
`ifdef MC_CTRL_TRAP_EN
            trap_set   = 1'b1;
            state_next = TRAP;
`else
            retire     = 1'b1;
            state_next = FETCH;
`endif
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc == OPC_STORE);
        if (dmem_ready) begin
          if (opc == OPC_STORE) begin
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        wb_sel     = (opc == OPC_LOAD);
        retire     = 1'b1;
        state_next = FETCH;
      end
      TRAP: state_next = TRAP;
      default: state_next = FETCH;
    endcase

    // The register already sits in FETCH during reset; gating here keeps the
    // outputs quiet until rst_n is released.
    if (!rst_n) begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      rf_we       = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      wb_sel      = 1'b0;
    end
  end

`ifdef MC_CTRL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trap_q <= 1'b0;
    else if (trap_set) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected outputs are queued when
// an instruction is scheduled and compared cycle by cycle as the DUT runs it.
module tb_mc_control;

  localparam int unsigned IW = 4;

  localparam logic [10:0] O_IREQ  = 11'h400;
  localparam logic [10:0] O_DREQ  = 11'h200;
  localparam logic [10:0] O_DWE   = 11'h100;
  localparam logic [10:0] O_IRWE  = 11'h080;
  localparam logic [10:0] O_PCWE  = 11'h040;
  localparam logic [10:0] O_PCSEL = 11'h020;
  localparam logic [10:0] O_RFWE  = 11'h010;
  localparam logic [10:0] O_IMM   = 11'h008;
  localparam logic [10:0] O_ALUFN = 11'h004;
  localparam logic [10:0] O_ALUBR = 11'h002;
  localparam logic [10:0] O_WBSEL = 11'h001;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h00208133;
  localparam logic [31:0] I_LD   = 32'h0000B103;
  localparam logic [31:0] I_SD   = 32'h0020B023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   inst = '0;
  logic          imem_req, imem_ready = 1'b0;
  logic          dmem_req, dmem_we, dmem_ready = 1'b0;
  logic          br_taken = 1'b0;
  logic          ir_we, pc_we, pc_sel, rf_we, alu_src_imm, wb_sel, trap;
  logic [1:0]    alu_op;
  logic [IW-1:0] instret;

  typedef struct {
    logic        ir;
    logic        dr;
    logic [10:0] out;
    logic        ret;
    logic        trp;
  } ent_t;

  ent_t          sbq[$];
  logic [IW-1:0] exp_instret = '0;
  int            checks = 0;
  int            errors = 0;
  string         cur = "";

  mc_control #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .br_taken(br_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .wb_sel(wb_sel), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
            alu_src_imm, alu_op, wb_sel};
  endfunction

  task automatic push(input logic ir, input logic dr, input logic [10:0] o,
                      input logic ret, input logic trp);
    ent_t e;
    e.ir = ir; e.dr = dr; e.out = o; e.ret = ret; e.trp = trp;
    sbq.push_back(e);
  endtask

  // Expected cycle sequence of one instruction; readies are driven high in
  // non-request states so that stray handshakes must be ignored.
  task automatic sched(input logic [31:0] ins, input int iw, input int dw,
                       input logic bt);
    logic [31:0] w;
    logic [4:0]  op;
    w  = ins;
    op = w[6:2];
    for (int i = 0; i < iw; i++) push(1'b0, 1'b1, O_IREQ, 1'b0, 1'b0);
    push(1'b1, 1'b1, O_IREQ | O_IRWE | O_PCWE, 1'b0, 1'b0);
    push(1'b1, 1'b1, '0, 1'b0, 1'b0);
    case (op)
      5'b00100: begin
        push(1'b1, 1'b1, O_IMM | O_ALUFN, 1'b0, 1'b0);
        push(1'b1, 1'b1, O_RFWE, 1'b1, 1'b0);
      end
      5'b01100: begin
        push(1'b1, 1'b1, O_ALUFN, 1'b0, 1'b0);
        push(1'b1, 1'b1, O_RFWE, 1'b1, 1'b0);
      end
      5'b00000: begin
        push(1'b1, 1'b1, O_IMM, 1'b0, 1'b0);
        for (int i = 0; i < dw; i++) push(1'b1, 1'b0, O_DREQ, 1'b0, 1'b0);
        push(1'b1, 1'b1, O_DREQ, 1'b0, 1'b0);
        push(1'b1, 1'b1, O_RFWE | O_WBSEL, 1'b1, 1'b0);
      end
      5'b01000: begin
        push(1'b1, 1'b1, O_IMM, 1'b0, 1'b0);
        for (int i = 0; i < dw; i++) push(1'b1, 1'b0, O_DREQ | O_DWE, 1'b0, 1'b0);
        push(1'b1, 1'b1, O_DREQ | O_DWE, 1'b1, 1'b0);
      end
      5'b11000: begin
        push(1'b1, 1'b1, bt ? (O_ALUBR | O_PCWE | O_PCSEL) : O_ALUBR, 1'b1, 1'b0);
      end
      default: begin
`ifdef MC_CTRL_TRAP_EN
        push(1'b1, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, '0, 1'b0, 1'b1);
`else
        push(1'b1, 1'b1, '0, 1'b1, 1'b0);
`endif
      end
    endcase
  endtask

  task automatic run_queue();
    ent_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      imem_ready = e.ir;
      dmem_ready = e.dr;
      #1;
      checks++;
      if (obs() !== e.out) begin
        errors++;
        $display("FAIL %s outputs got %b exp %b", cur, obs(), e.out);
      end
      checks++;
      if (trap !== e.trp) begin
        errors++;
        $display("FAIL %s trap got %b exp %b", cur, trap, e.trp);
      end
      @(posedge clk);
      #1;
      if (e.ret) exp_instret = exp_instret + 1'b1;
      checks++;
      if (instret !== exp_instret) begin
        errors++;
        $display("FAIL %s instret got %0d exp %0d", cur, instret, exp_instret);
      end
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #2;
    checks++;
    if (obs() !== 11'h000 || instret !== '0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got out=%b instret=%0d trap=%b exp 0/0/0",
               obs(), instret, trap);
    end
    @(negedge clk);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release imem_req got %b exp 1", imem_req);
    end
  endtask

  task automatic test_addi();
    cur = "addi"; inst = I_ADDI; sched(I_ADDI, 0, 0, 1'b0); run_queue();
  endtask

  task automatic test_load_wait();
    cur = "ld_wait"; inst = I_LD; sched(I_LD, 0, 3, 1'b0); run_queue();
  endtask

  task automatic test_store();
    cur = "sd"; inst = I_SD; sched(I_SD, 1, 1, 1'b0); run_queue();
  endtask

  task automatic test_branch();
    cur = "beq_taken"; inst = I_BEQ; br_taken = 1'b1; sched(I_BEQ, 0, 0, 1'b1); run_queue();
    cur = "beq_not"; br_taken = 1'b0; sched(I_BEQ, 0, 0, 1'b0); run_queue();
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [5];
    tbl[0] = I_ADDI; tbl[1] = I_ADD; tbl[2] = I_LD; tbl[3] = I_SD; tbl[4] = I_BEQ;
    cur = "b2b_wrap";
    for (int n = 0; n < 20; n++) begin
      inst     = tbl[$urandom_range(0, 4)];
      br_taken = 1'($urandom_range(0, 1));
      sched(inst, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), br_taken);
      run_queue();
    end
  endtask

  task automatic test_illegal();
    cur = "illegal"; inst = I_ILL; sched(I_ILL, 0, 0, 1'b0); run_queue();
  endtask

  task automatic test_reset_mid_mem();
`ifdef MC_CTRL_TRAP_EN
    @(negedge clk); rst_n = 1'b0; exp_instret = '0;
    @(negedge clk); imem_ready = 1'b0; dmem_ready = 1'b0; rst_n = 1'b1;
`endif
    cur = "ld_pre";
    inst = I_LD;
    sched(I_LD, 0, 0, 1'b0);
    run_queue();
    cur = "rst_mid_mem";
    @(negedge clk); imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mem_entry dmem_req got %b exp 1", dmem_req);
    end
    #2;
    rst_n = 1'b0;
    exp_instret = '0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL mid_reset dmem_req=%b instret=%0d exp 0/0", dmem_req, instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL after_reset imem_req=%b dmem_req=%b exp 1/0", imem_req, dmem_req);
    end
    cur = "post_reset_addi";
    inst = I_ADDI;
    sched(I_ADDI, 0, 0, 1'b0);
    run_queue();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
